counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
Sequences the 12-bit pattern counter through a programmable list of segments. Each segment specifies a mode (Xmode) and a load value (LoadVal). For every segment the block presents Xmode/LoadVal to the counter, holds cnt_enb high for a computed dwell time, then advances to the next segment. It sits between the register/config interface and the counter datapath, and reports segment and sequence completion to the top level.

Parameters:
NUM_SEG, 4, number of segment table entries (power of 2)
IDX_W, 2, segment index width = log2(NUM_SEG)
VAL_W, 12, load value width (matches counter)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  segment table write strobe
cfg_addr  in  IDX_W  table entry to write
cfg_mode  in  2  mode for entry
cfg_val  in  VAL_W  load value for entry
seq_last  in  IDX_W  index of last segment; sampled on accepted start
loop_en  in  1  1 = restart at segment 0 after last segment
start  in  1  begin sequence (pulse)
stop  in  1  abort sequence (pulse)
cnt_enb  out  1  counter enable
Xmode  out  2  counter mode for current segment
LoadVal  out  VAL_W  counter load value for current segment
seg_idx  out  IDX_W  current segment index
busy  out  1  high when not IDLE
seg_done  out  1  1-cycle pulse at end of each segment
seq_done  out  1  1-cycle pulse at end of a non-looping sequence

Behaviour:
- Reset: clk and rst_n are fixed as above (one clock; reset synchronous, active-low). On reset every output is 0, every table entry is {mode=0, val=0}, state = IDLE, latched seq_last = 0, timer = 0.
- Table writes: a write occurs on the clk edge when cfg_we=1, in any state. Each segment reads its entry only in LOAD, so a write to an active or upcoming entry takes effect the next time that entry is loaded.
- Dwell: dwell = (val+1) << mode cycles, where mode 00/01/10/11 = x1/x2/x4/x8. The timer is VAL_W+3 = 15 bits. The range runs from 1 cycle (val=0, mode=0) to 32768 cycles (val=4095, mode=3). No overflow is possible.
- State IDLE: cnt_enb=0 and busy=0. On start=1 and stop=0: latch seq_last, set seg_idx=0, go to LOAD.
- State LOAD (1 cycle): busy=1 and cnt_enb=0. Register Xmode and LoadVal from table[seg_idx], preload timer = dwell-1, go to RUN.
- State RUN: cnt_enb=1. Xmode and LoadVal are held stable. The timer decrements each cycle.
- Timer reaches 0 in RUN: assert seg_done for 1 cycle on the next edge. Then:
  - If seg_idx != latched seq_last: seg_idx+1, go to LOAD.
  - Else if loop_en=1 (sampled this cycle): seg_idx=0, go to LOAD.
  - Else: assert seq_done together with seg_done, go to IDLE.
- Segment timing: each segment occupies exactly 1 LOAD cycle plus dwell RUN cycles.
- stop=1 in any state: go to IDLE on the next edge. cnt_enb, busy and seg_idx drop to 0. No seg_done or seq_done is issued. Xmode and LoadVal hold their last values.
- start while busy: ignored. If start and stop are asserted in the same cycle, stop wins.
- seq_last < NUM_SEG always holds (width-limited). seq_last=0 gives a single-segment sequence.
- rst_n=0 in mid-sequence: full reset on that edge, including clearing the table.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package: mode encoding constants (MODE_X1..MODE_X8), state encoding (IDLE, LOAD, RUN), VAL_W and timer width constants.
- Sub-module dwell_timer: inputs load, val, mode; down-count; output zero flag. Shifter and decrement live here.
- Table and FSM stay in counter_sched.

Test Plan:
- Reset check: rst_n=0 for 2 cycles -> all outputs 0 and busy=0. A start issued afterwards with an unwritten table -> LoadVal=0, Xmode=0, cnt_enb high for exactly 1 cycle.
- Single segment: entry0={mode=0, val=3}, seq_last=0, start -> LOAD for 1 cycle, then cnt_enb=1 for 4 cycles with LoadVal=3. seg_done and seq_done pulse together, then busy=0.
- Scaling: entries {01,50}, {10,50}, {11,4000}, seq_last=2 -> cnt_enb high for 102, 204 and 32008 cycles respectively. Three seg_done pulses, one seq_done, seg_idx 0→1→2.
- Loop and stop: 2 segments with val=1, mode=0, loop_en=1 -> seg_idx pattern 0,1,0,1… with no seq_done. Stop in the middle of RUN -> next cycle cnt_enb=0, busy=0, no pulses.
- Corner controls: start and stop in the same cycle -> stays IDLE. Start while busy -> no restart, timing unchanged. Overwrite entry1 while segment 0 runs -> segment 1 uses the new value.
- Max dwell and reset: entry0={11,4095} -> 32768 RUN cycles. Assert rst_n=0 at cycle 1000 -> outputs 0 on that edge, and the table reads back as zero on the next start.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// ---------------------------------------------------------------------------
// counter_sched_pkg : shared mode/state encodings and width constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_sched_pkg;

  localparam int SEG_VAL_W = 12;
  localparam int SEG_TMR_W = SEG_VAL_W + 3;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;
  localparam logic [1:0] MODE_X8 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_sched_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer : preloads (val+1)<<mode - 1 and counts down to a zero flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dwell_timer
  import counter_sched_pkg::*;
#(
  parameter int VAL_W = SEG_VAL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [VAL_W-1:0] val_i,
  input  logic [1:0]       mode_i,
  output logic             zero_o
);

  localparam int TMR_W = VAL_W + 3;

  // One extra bit so (4095+1)<<3 = 32768 is representable before the -1.
  logic [TMR_W:0]   w_dwell;
  logic [TMR_W:0]   w_dwell_m1;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;

  assign w_dwell    = ({{(TMR_W+1-VAL_W){1'b0}}, val_i} + 1'b1) << mode_i;
  assign w_dwell_m1 = w_dwell - 1'b1;
  assign zero_o     = (timer_q == '0);

  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = w_dwell_m1[TMR_W-1:0];
    end else if (en_i && !zero_o) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_sched.sv
// ---------------------------------------------------------------------------
// counter_sched : steps the pattern counter through a programmable segment list
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int IDX_W   = 2,
  parameter int VAL_W   = SEG_VAL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [1:0]       cfg_mode,
  input  logic [VAL_W-1:0] cfg_val,
  input  logic [IDX_W-1:0] seq_last,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             cnt_enb,
  output logic [1:0]       Xmode,
  output logic [VAL_W-1:0] LoadVal,
  output logic [IDX_W-1:0] seg_idx,
  output logic             busy,
  output logic             seg_done,
  output logic             seq_done
);

  logic [1:0]       mode_tab_q [NUM_SEG];
  logic [VAL_W-1:0] val_tab_q  [NUM_SEG];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             seg_done_d, seq_done_d;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [1:0]       xmode_q;
  logic [VAL_W-1:0] loadval_q;
  logic             cnt_enb_q, busy_q, seg_done_q, seq_done_q;

  dwell_timer #(.VAL_W(VAL_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .val_i  (val_tab_q[idx_q]),
    .mode_i (mode_tab_q[idx_q]),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    seg_done_d = 1'b0;
    seq_done_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = seq_last;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tmr_load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (tmr_zero) begin
          seg_done_d = 1'b1;
          if (idx_q != last_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end else if (loop_en) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            seq_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start.
    if (stop) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      seg_done_d = 1'b0;
      seq_done_d = 1'b0;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        mode_tab_q[i] <= MODE_X1;
        val_tab_q[i]  <= '0;
      end
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      xmode_q    <= '0;
      loadval_q  <= '0;
      cnt_enb_q  <= 1'b0;
      busy_q     <= 1'b0;
      seg_done_q <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      if (cfg_we) begin
        mode_tab_q[cfg_addr] <= cfg_mode;
        val_tab_q[cfg_addr]  <= cfg_val;
      end
      if (tmr_load) begin
        xmode_q   <= mode_tab_q[idx_q];
        loadval_q <= val_tab_q[idx_q];
      end
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_enb_q  <= (state_d == ST_RUN);
      busy_q     <= (state_d != ST_IDLE);
      seg_done_q <= seg_done_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign cnt_enb  = cnt_enb_q;
  assign Xmode    = xmode_q;
  assign LoadVal  = loadval_q;
  assign seg_idx  = idx_q;
  assign busy     = busy_q;
  assign seg_done = seg_done_q;
  assign seq_done = seq_done_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_sched.sv
// ---------------------------------------------------------------------------
// tb_counter_sched : directed scoreboard bench for counter_sched
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counter_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [1:0]  cfg_mode = '0;
  logic [11:0] cfg_val = '0;
  logic [1:0]  seq_last = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cnt_enb;
  logic [1:0]  Xmode;
  logic [11:0] LoadVal;
  logic [1:0]  seg_idx;
  logic        busy, seg_done, seq_done;

  counter_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_val(cfg_val), .seq_last(seq_last),
    .loop_en(loop_en), .start(start), .stop(stop), .cnt_enb(cnt_enb),
    .Xmode(Xmode), .LoadVal(LoadVal), .seg_idx(seg_idx), .busy(busy),
    .seg_done(seg_done), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int mode;
    int val;
    int len;
    bit seq;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Segment monitor: measures each cnt_enb run and scores it at seg_done.
  int          run_len = 0;
  logic [1:0]  cap_mode, cap_idx;
  logic [11:0] cap_val;
  bit          unstable = 1'b0;
  exp_t        me;

  always @(negedge clk) begin
    if (seg_done) begin
      chk("seg_done_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        me = sb.pop_front();
        chk("seg_len", run_len, me.len);
        chk("seg_idx", cap_idx, me.idx);
        chk("seg_mode", cap_mode, me.mode);
        chk("seg_val", cap_val, me.val);
        chk("seq_done", seq_done, me.seq);
        chk("seg_stable", unstable, 1'b0);
      end
    end
    if (seq_done) chk("seq_done_with_seg_done", seg_done, 1'b1);
    if (cnt_enb) begin
      if (run_len == 0) begin
        cap_mode = Xmode;
        cap_val  = LoadVal;
        cap_idx  = seg_idx;
        unstable = 1'b0;
      end else if (Xmode !== cap_mode || LoadVal !== cap_val || seg_idx !== cap_idx) begin
        unstable = 1'b1;
      end
      run_len++;
    end else begin
      run_len = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int m, input int v);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_mode = 2'(m); cfg_val = 12'(v);
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic push(input int i, input int m, input int v, input int len, input bit sq);
    exp_t e;
    e.idx = i; e.mode = m; e.val = v; e.len = len; e.seq = sq;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt_enb"}, cnt_enb, 1'b0);
    chk({tag, "_Xmode"}, Xmode, 0);
    chk({tag, "_LoadVal"}, LoadVal, 0);
    chk({tag, "_seg_idx"}, seg_idx, 0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_seg_done"}, seg_done, 1'b0);
    chk({tag, "_seq_done"}, seq_done, 1'b0);
  endtask

  initial begin
    int n;
    // Reset
    rst_n = 1'b0;
    step(2);
    chk_zero("reset");
    rst_n = 1'b1;
    step(1);

    // Unwritten table: single 1-cycle segment
    seq_last = 2'd0;
    push(0, 0, 0, 1, 1'b1);
    pulse_start();
    chk("load_busy", busy, 1'b1);
    chk("load_cnt_enb", cnt_enb, 1'b0);
    wait_idle("blank", 20);

    // Single segment, val=3 -> 4 cycles
    wr(0, 0, 3);
    push(0, 0, 3, 4, 1'b1);
    pulse_start();
    wait_idle("single", 20);

    // Scaling across modes
    wr(0, 1, 50);
    wr(1, 2, 50);
    wr(2, 3, 4000);
    seq_last = 2'd2;
    push(0, 1, 50, 102, 1'b0);
    push(1, 2, 50, 204, 1'b0);
    push(2, 3, 4000, 32008, 1'b1);
    pulse_start();
    wait_idle("scale", 33000);

    // Looping 0,1,0,1 then stop mid-RUN
    wr(0, 0, 1);
    wr(1, 0, 1);
    seq_last = 2'd1;
    loop_en  = 1'b1;
    push(0, 0, 1, 2, 1'b0);
    push(1, 0, 1, 2, 1'b0);
    push(0, 0, 1, 2, 1'b0);
    push(1, 0, 1, 2, 1'b0);
    pulse_start();
    n = 0;
    while ((sb.size() != 0 || !cnt_enb) && n < 100) begin
      step(1);
      n++;
    end
    chk("loop_reached_run", cnt_enb, 1'b1);
    chk("loop_sb_drained", sb.size(), 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    loop_en = 1'b0;
    chk("stop_cnt_enb", cnt_enb, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_seg_idx", seg_idx, 0);
    chk("stop_seg_done", seg_done, 1'b0);
    chk("stop_seq_done", seq_done, 1'b0);
    chk("stop_Xmode_hold", Xmode, 0);
    chk("stop_LoadVal_hold", LoadVal, 1);
    step(3);
    chk("stop_stays_idle", busy, 1'b0);

    // Start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    step(2);
    chk("startstop_cnt_enb", cnt_enb, 1'b0);

    // Start while busy ignored; entry1 rewritten while segment 0 runs
    wr(0, 0, 9);
    wr(1, 0, 2);
    seq_last = 2'd1;
    push(0, 0, 9, 10, 1'b0);
    push(1, 1, 7, 16, 1'b1);
    pulse_start();
    step(2);
    pulse_start();
    wr(1, 1, 7);
    wait_idle("busy_start", 60);

    // Max dwell, full length
    wr(0, 3, 4095);
    seq_last = 2'd0;
    push(0, 3, 4095, 32768, 1'b1);
    pulse_start();
    wait_idle("maxdwell", 33000);

    // Max dwell interrupted by reset
    pulse_start();
    step(999);
    chk("maxdwell_active_cnt_enb", cnt_enb, 1'b1);
    chk("maxdwell_active_LoadVal", LoadVal, 4095);
    rst_n = 1'b0;
    step(1);
    chk_zero("midreset");
    rst_n = 1'b1;
    step(1);
    push(0, 0, 0, 1, 1'b1);
    pulse_start();
    wait_idle("after_reset", 20);
    step(2);
    chk("sb_empty_at_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
